// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter/sequencer sharing one tinyALU between NUM_REQ requesters.
// Optional watchdog on the RUN state: define TINYALU_ARB_TIMEOUT_EN.
module tinyalu_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 15,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    input  logic [3*NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [15:0]            rsp_result,
    output logic                   rsp_err,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [2:0]             alu_op,
    output logic                   alu_start,
    input  logic                   alu_done,
    input  logic [15:0]            alu_result
);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr, cur_id, sel, nxt_ptr;
    logic           found, legal, expire;
    logic [7:0]     sel_a, sel_b;
    logic [2:0]     sel_op;

    // First set request at or after the pointer, wrapping around.
    always_comb begin : pick
        int j;
        j      = 0;
        found  = 1'b0;
        sel    = '0;
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                sel    = IDW'(j);
                sel_a  = req_a[8*j +: 8];
                sel_b  = req_b[8*j +: 8];
                sel_op = req_op[3*j +: 3];
            end
        end
    end

    assign legal   = (sel_op != 3'd0) && (sel_op <= 3'd4);
    assign nxt_ptr = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;

`ifdef TINYALU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (state == RUN)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    // alu_done on the expiry edge still produces a normal response
    assign expire = (state == RUN) && !alu_done && (int'(cnt) + 1 >= TIMEOUT_CYCLES);
`else
    assign expire = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // A RESP entered straight from IDLE (no_op/illegal) spends one cycle
    // with rsp_valid low so the response follows the grant pulse.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = legal ? RUN : RESP;
            RUN:     if (alu_done || expire) state_n = RESP;
            RESP:    if (rsp_valid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            cur_id     <= '0;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_start  <= 1'b0;
        end else begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    gnt    <= NUM_REQ'(1) << sel;
                    ptr    <= nxt_ptr;
                    cur_id <= sel;
                    if (legal) begin
                        alu_a     <= sel_a;
                        alu_b     <= sel_b;
                        alu_op    <= sel_op;
                        alu_start <= 1'b1;
                    end
                end
                RUN: if (alu_done || expire) begin
                    alu_start  <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_id     <= cur_id;
                    rsp_result <= expire ? 16'h0000 : alu_result;
                    rsp_err    <= expire;
                end
                RESP: if (!rsp_valid) begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= cur_id;
                    rsp_result <= 16'h0000;
                    rsp_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
